// File: rtl/piso_pkg.sv
// Shared types and constants for the piso_tx parallel-in/serial-out transmitter.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } piso_state_e;

  // Level driven on sout whenever no data bit is being presented.
  localparam logic IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/piso_tx_if.sv
// Load handshake, serial output pair and debug view of the piso_tx transmitter.
interface piso_tx_if #(
  parameter int WIDTH = 8
);
  import piso_pkg::*;

  localparam int CW = $clog2(WIDTH);

  // A word transfers on a rising edge where load_valid && load_ready; load_ready
  // is high in IDLE and DONE only, and load_valid may drop once the edge passes.
  logic [WIDTH-1:0] din;
  logic             load_valid;
  logic             load_ready;
  logic             en;
  logic             sout;
  logic             sout_n;
  logic             sout_valid;
  logic             busy;
  logic             done;
  piso_state_e      dbg_state;
  logic [CW-1:0]    dbg_cnt;

  modport master (
    output din, load_valid, en,
    input  load_ready, sout, sout_n, sout_valid, busy, done, dbg_state, dbg_cnt
  );

  modport slave (
    input  din, load_valid, en,
    output load_ready, sout, sout_n, sout_valid, busy, done, dbg_state, dbg_cnt
  );

endinterface

// File: rtl/piso_bit_counter.sv
// Modulo-WIDTH bit counter: synchronous clear, count enable, terminal-count flag.
module piso_bit_counter #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic          tc_o
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == LAST);

endmodule

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: loads a word on a valid/ready handshake and
// shifts it out one bit per en tick on a registered complementary pair.
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  piso_tx_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  piso_state_e      state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             sout_q, sout_d;
  logic             sout_n_q;
  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_tc;
  logic [CW-1:0]    cnt;

  function automatic logic out_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  piso_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .cnt_o (cnt),
    .tc_o  (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.load_valid) begin
          shreg_d = bus.din;
          cnt_clr = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.en) begin
          // The final bit stays on sout for its whole tick; only the state moves on.
          if (cnt_tc) begin
            state_d = DONE;
          end else begin
            shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                : {1'b0, shreg_q[WIDTH-1:1]};
            cnt_en  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    sout_d = (state_d == SHIFT) ? out_bit(shreg_d) : IDLE_LEVEL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      sout_q   <= IDLE_LEVEL;
      sout_n_q <= ~IDLE_LEVEL;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      sout_q   <= sout_d;
      sout_n_q <= ~sout_d;
    end
  end

  assign bus.load_ready = (state_q != SHIFT);
  assign bus.busy       = (state_q == SHIFT);
  assign bus.sout_valid = (state_q == SHIFT);
  assign bus.done       = (state_q == DONE);
  assign bus.sout       = sout_q;
  assign bus.sout_n     = sout_n_q;
  assign bus.dbg_state  = state_q;
  assign bus.dbg_cnt    = cnt;

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: an MSB-first and an LSB-first instance share one stimulus
// stream; a negedge monitor scores every consumed bit against expected queues.
module tb_piso_tx;
  import piso_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din = '0;
  logic       lv  = 1'b0;
  logic       en  = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  logic [0:0] exp_m_q[$];
  logic [0:0] exp_l_q[$];
  int         bit_cnt[2];
  logic       done_pend[2];

  piso_tx_if #(.WIDTH(8)) m_if ();
  piso_tx_if #(.WIDTH(8)) l_if ();

  assign m_if.din = din;  assign m_if.load_valid = lv;  assign m_if.en = en;
  assign l_if.din = din;  assign l_if.load_valid = lv;  assign l_if.en = en;

  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(m_if));
  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(l_if));

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic mon_step(input string tag, input int sel, input logic s, input logic sn,
                          input logic sv, input logic dn);
    logic [0:0] b;
    logic       last;
    int         qsz;
    last = 1'b0;
    qsz  = (sel == 0) ? exp_m_q.size() : exp_l_q.size();
    chk({tag, "_compl"}, s ^ sn, 1);
    chk({tag, "_done"}, dn, done_pend[sel]);
    if (!sv) chk({tag, "_idle_lvl"}, s, 0);
    if (sv && en) begin
      if (qsz == 0) begin
        chk({tag, "_extra_bit"}, 1, 0);
      end else begin
        b = (sel == 0) ? exp_m_q.pop_front() : exp_l_q.pop_front();
        chk({tag, "_bit"}, s, b);
        bit_cnt[sel]++;
        if (bit_cnt[sel] == 8) begin
          bit_cnt[sel] = 0;
          last = 1'b1;
        end
      end
    end
    done_pend[sel] = last;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      bit_cnt   = '{0, 0};
      done_pend = '{1'b0, 1'b0};
    end else begin
      mon_step("m", 0, m_if.sout, m_if.sout_n, m_if.sout_valid, m_if.done);
      mon_step("l", 1, l_if.sout, l_if.sout_n, l_if.sout_valid, l_if.done);
    end
  end

  // ---------------- drivers (called at posedge + 1) ----------------
  task automatic load_word(input logic [7:0] w);
    chk("m_load_ready", m_if.load_ready, 1);
    chk("l_load_ready", l_if.load_ready, 1);
    din = w;
    lv  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_m_q.push_back(w[7-i]);
      exp_l_q.push_back(w[i]);
    end
    @(posedge clk); #1;
    lv = 1'b0;
    chk("m_first_bit", m_if.sout, w[7]);
    chk("l_first_bit", l_if.sout, w[0]);
    chk("m_busy", m_if.busy, 1);
  endtask

  // mode 0: en always high; 1: pattern 0,0,1; 2: random ticks
  task automatic run_word(input int mode, input int max_cyc);
    int  k;
    logic found;
    found = 1'b0;
    k = 0;
    while (k < max_cyc && !found) begin
      if (m_if.done) begin
        found = 1'b1;
      end else begin
        case (mode)
          0:       en = 1'b1;
          1:       en = (k % 3 == 2);
          default: en = ($urandom_range(0, 2) == 0);
        endcase
        @(posedge clk); #1;
        k++;
      end
    end
    en = 1'b0;
    chk("done_seen", found, 1);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    chk("m_back_idle", m_if.dbg_state, IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_sout",       m_if.sout, 0);
    chk("rst_sout_n",     m_if.sout_n, 1);
    chk("rst_load_ready", m_if.load_ready, 1);
    chk("rst_busy",       m_if.busy, 0);
    chk("rst_done",       m_if.done, 0);
    chk("rst_valid",      m_if.sout_valid, 0);
    chk("rst_state",      m_if.dbg_state, IDLE);
    chk("rst_cnt",        m_if.dbg_cnt, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // MSB-first A5 with continuous en
    load_word(8'hA5);
    run_word(0, 40);
    idle_cycle();

    // en gating: bit 0 of 01 is held through two idle ticks; en high during load is ignored
    en = 1'b1;
    load_word(8'h01);
    run_word(1, 60);
    idle_cycle();
    load_word(8'($urandom_range(0, 255)));
    run_word(2, 120);
    idle_cycle();

    // back-to-back: second word accepted in the DONE cycle
    load_word(8'hFF);
    run_word(0, 40);
    chk("b2b_done",      m_if.done, 1);
    chk("b2b_gap_valid", m_if.sout_valid, 0);
    load_word(8'h00);
    run_word(0, 40);
    idle_cycle();

    // load attempt while busy is ignored
    load_word(8'hC3);
    en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    din = 8'h3C;
    lv  = 1'b1;
    chk("busy_load_ready", m_if.load_ready, 0);
    @(posedge clk); #1;
    lv = 1'b0;
    chk("busy_still", m_if.busy, 1);
    run_word(0, 40);
    idle_cycle();

    // reset mid-word
    load_word(8'hAA);
    en = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_sout",   m_if.sout, 0);
    chk("mid_rst_sout_n", m_if.sout_n, 1);
    chk("mid_rst_ready",  m_if.load_ready, 1);
    chk("mid_rst_busy",   m_if.busy, 0);
    chk("mid_rst_done",   m_if.done, 0);
    chk("mid_rst_valid",  l_if.sout_valid, 0);
    exp_m_q.delete();
    exp_l_q.delete();
    en = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_done", m_if.done, 0);
      chk("post_rst_ready",   m_if.load_ready, 1);
    end
    load_word(8'h0F);
    run_word(0, 40);
    idle_cycle();

    repeat (2) @(posedge clk);
    #1;
    chk("m_q_empty", exp_m_q.size(), 0);
    chk("l_q_empty", exp_l_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
